dvi_timing_ctrl: RTL and testbench

DVI_TIMING_CTRL -- requirements
Module: dvi_timing_ctrl

---
 rtl/dvi_timing_ctrl.sv | 140 ++++++++++++++
 tb/tb_dvi_timing_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_ctrl.sv
// DVI/TMDS video timing generator: raster counters, sync/data-enable generation
// and pixel hand-off from an upstream valid/ready source into the three encoders.
module dvi_timing_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        de,
  output logic [1:0]  ctrl0,
  output logic [1:0]  ctrl1,
  output logic [1:0]  ctrl2,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic        line_start,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HX      = HW + 1;
  localparam int VX      = VW + 1;

  // Region bounds carry one spare bit so a sync that ends exactly at the total still fits.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HX-1:0] H_ACT_E  = HX'(H_ACTIVE);
  localparam logic [HX-1:0] HS_BEG   = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] HS_END   = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] V_ACT_E  = VX'(V_ACTIVE);
  localparam logic [VX-1:0] VS_BEG   = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] VS_END   = VX'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          POL      = (SYNC_ACTIVE_LOW != 0);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          running;
  logic          active;
  logic          hsync;
  logic          vsync;

  assign running = (state == RUN);
  assign h_last  = (h_cnt == H_LAST);
  assign v_last  = (v_cnt == V_LAST);
  assign active  = running && ({1'b0, h_cnt} < H_ACT_E) && ({1'b0, v_cnt} < V_ACT_E);
  assign hsync   = running && ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
  assign vsync   = running && ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);

  assign pix_ready = active;
  assign ctrl1     = 2'b00;
  assign ctrl2     = 2'b00;

  // Leaving RUN is only considered on the last pixel of the frame, so frames never truncate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            h_cnt <= '0;
            v_cnt <= '0;
          end
        end
        RUN: begin
          if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
              v_cnt <= '0;
              if (!enable) state <= IDLE;
            end else begin
              v_cnt <= v_cnt + 1'b1;
            end
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      ctrl0       <= {POL, POL};
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      de          <= active;
      ctrl0       <= {vsync ^ POL, hsync ^ POL};
      line_start  <= active && (h_cnt == '0);
      frame_start <= active && (h_cnt == '0) && (v_cnt == '0);
      if (active && pix_valid) begin
        red   <= pix_data[23:16];
        green <= pix_data[15:8];
        blue  <= pix_data[7:0];
      end else begin
        red   <= 8'h00;
        green <= 8'h00;
        blue  <= 8'h00;
      end
      // A fresh starvation outranks a clear in the same cycle.
      if (active && !pix_valid)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Bench for dvi_timing_ctrl: two small raster configurations driven with shared
// random stimulus and compared every cycle against a linear-position frame model.
module tb_dvi_timing_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        underrun_clr;

  logic        rdy_o [2];
  logic        de_o  [2];
  logic [1:0]  c0_o  [2];
  logic [1:0]  c1_o  [2];
  logic [1:0]  c2_o  [2];
  logic [7:0]  r_o   [2];
  logic [7:0]  g_o   [2];
  logic [7:0]  b_o   [2];
  logic        fs_o  [2];
  logic        ls_o  [2];
  logic        ur_o  [2];

  int errors = 0;
  int checks = 0;

  int ha [2], ht [2], va [2], vt [2];
  int hs0 [2], hs1 [2], vs0 [2], vs1 [2];
  logic pol [2];

  logic        m_run [2];
  int          m_pos [2];
  logic        m_ur  [2];
  logic        e_de  [2];
  logic        e_fs  [2];
  logic        e_ls  [2];
  logic        e_ur  [2];
  logic [1:0]  e_c0  [2];
  logic [23:0] e_rgb [2];

  int cnt_de [2], cnt_ls [2], cnt_fs [2], cnt_hs [2], cnt_vs [2];

  dvi_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(rdy_o[0]), .de(de_o[0]),
    .ctrl0(c0_o[0]), .ctrl1(c1_o[0]), .ctrl2(c2_o[0]),
    .red(r_o[0]), .green(g_o[0]), .blue(b_o[0]),
    .frame_start(fs_o[0]), .line_start(ls_o[0]), .underrun(ur_o[0]),
    .underrun_clr(underrun_clr)
  );

  dvi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(rdy_o[1]), .de(de_o[1]),
    .ctrl0(c0_o[1]), .ctrl1(c1_o[1]), .ctrl2(c2_o[1]),
    .red(r_o[1]), .green(g_o[1]), .blue(b_o[1]),
    .frame_start(fs_o[1]), .line_start(ls_o[1]), .underrun(ur_o[1]),
    .underrun_clr(underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // The model walks one flat position through the frame; h/v are derived by division.
  function automatic logic m_active(input int k);
    int h = m_pos[k] % ht[k];
    int v = m_pos[k] / ht[k];
    return m_run[k] && (h < ha[k]) && (v < va[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_pos[k] = 0; m_ur[k] = 1'b0;
      e_de[k] = 1'b0; e_fs[k] = 1'b0; e_ls[k] = 1'b0; e_ur[k] = 1'b0;
      e_c0[k] = {pol[k], pol[k]}; e_rgb[k] = 24'h0;
    end
  endtask

  task automatic check_output(input int k);
    chk("de", k, de_o[k], e_de[k]);
    chk("ctrl0", k, c0_o[k], e_c0[k]);
    chk("ctrl1", k, c1_o[k], 2'b00);
    chk("ctrl2", k, c2_o[k], 2'b00);
    chk("rgb", k, {r_o[k], g_o[k], b_o[k]}, e_rgb[k]);
    chk("frame_start", k, fs_o[k], e_fs[k]);
    chk("line_start", k, ls_o[k], e_ls[k]);
    chk("underrun", k, ur_o[k], e_ur[k]);
  endtask

  // One clock: drive at the falling edge, check pix_ready, predict, then check registered outputs.
  task automatic apply_stimulus(input logic en, input logic pv, input logic [23:0] data, input logic clr);
    enable = en; pix_valid = pv; pix_data = data; underrun_clr = clr;
    #1;
    for (int k = 0; k < 2; k++) begin
      int h = m_pos[k] % ht[k];
      int v = m_pos[k] / ht[k];
      logic act = m_active(k);
      logic hs = m_run[k] && (h >= hs0[k]) && (h < hs1[k]);
      logic vs = m_run[k] && (v >= vs0[k]) && (v < vs1[k]);
      chk("pix_ready", k, rdy_o[k], act);
      e_de[k]  = act;
      e_c0[k]  = {vs ^ pol[k], hs ^ pol[k]};
      e_rgb[k] = (act && pv) ? data : 24'h0;
      e_ls[k]  = act && (h == 0);
      e_fs[k]  = act && (m_pos[k] == 0);
      if (act && !pv) m_ur[k] = 1'b1;
      else if (clr)   m_ur[k] = 1'b0;
      e_ur[k] = m_ur[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!m_run[k]) begin
        if (en) begin m_run[k] = 1'b1; m_pos[k] = 0; end
      end else if (m_pos[k] == ht[k] * vt[k] - 1 && !en) begin
        m_run[k] = 1'b0; m_pos[k] = 0;
      end else begin
        m_pos[k] = (m_pos[k] + 1) % (ht[k] * vt[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_output(k);
      cnt_de[k] += int'(de_o[k]);
      cnt_ls[k] += int'(ls_o[k]);
      cnt_fs[k] += int'(fs_o[k]);
      cnt_hs[k] += int'(c0_o[k][0] != pol[k]);
      cnt_vs[k] += int'(c0_o[k][1] != pol[k]);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      cnt_de[k] = 0; cnt_ls[k] = 0; cnt_fs[k] = 0; cnt_hs[k] = 0; cnt_vs[k] = 0;
    end
  endtask

  function automatic logic rnd_pct(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  initial begin
    int b_de, b_ls, b_hs, b_vs, n, drop_pos;
    logic hit;

    ha[0] = 16; ht[0] = 28; va[0] = 6; vt[0] = 13;
    hs0[0] = 19; hs1[0] = 23; vs0[0] = 8; vs1[0] = 10; pol[0] = 1'b1;
    ha[1] = 4;  ht[1] = 8;  va[1] = 2; vt[1] = 5;
    hs0[1] = 5;  hs1[1] = 7;  vs0[1] = 3; vs1[1] = 4;  pol[1] = 1'b0;

    rst_n = 1'b0; enable = 1'b0; pix_valid = 1'b0; pix_data = 24'h0; underrun_clr = 1'b0;
    model_reset();
    clear_counts();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_output(k);
      chk("reset_pix_ready", k, rdy_o[k], 1'b0);
    end
    rst_n = 1'b1;

    // Constant-valid run: one full frame of dut_a, first frame of dut_b snapshotted.
    apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
    clear_counts();
    b_de = 0; b_ls = 0; b_hs = 0; b_vs = 0;
    for (int i = 0; i < 28 * 13; i++) begin
      apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
      if (i == 39) begin
        b_de = cnt_de[1]; b_ls = cnt_ls[1]; b_hs = cnt_hs[1]; b_vs = cnt_vs[1];
      end
    end
    chk("frame_de_cycles", 0, cnt_de[0], 96);
    chk("frame_line_starts", 0, cnt_ls[0], 6);
    chk("frame_starts", 0, cnt_fs[0], 1);
    chk("frame_hsync_cycles", 0, cnt_hs[0], 52);
    chk("frame_vsync_cycles", 0, cnt_vs[0], 56);
    chk("frame_de_cycles", 1, b_de, 8);
    chk("frame_line_starts", 1, b_ls, 2);
    chk("frame_hsync_cycles", 1, b_hs, 10);
    chk("frame_vsync_cycles", 1, b_vs, 8);

    // Starvation at (5,3), then starvation coinciding with clear, then a clean clear.
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (m_run[0] && m_pos[0] == 3 * 28 + 5) hit = 1'b1;
      else apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
    end
    chk("reach_5_3", 0, hit, 1'b1);
    apply_stimulus(1'b1, 1'b0, 24'hABCDEF, 1'b0);
    chk("starve_rgb", 0, {r_o[0], g_o[0], b_o[0]}, 24'h000000);
    chk("starve_flag", 0, ur_o[0], 1'b1);
    apply_stimulus(1'b1, 1'b0, 24'h123456, 1'b1);
    chk("set_beats_clear", 0, ur_o[0], 1'b1);
    apply_stimulus(1'b1, 1'b1, 24'h654321, 1'b1);
    chk("clear_flag", 0, ur_o[0], 1'b0);
    chk("pixel_pass", 0, {r_o[0], g_o[0], b_o[0]}, 24'h654321);

    // Drop enable mid-frame: the frame must run to its last pixel before idling.
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (m_run[0] && m_pos[0] == 4 * 28 + 10) hit = 1'b1;
      else apply_stimulus(1'b1, rnd_pct(90), 24'($urandom), rnd_pct(10));
    end
    chk("reach_10_4", 0, hit, 1'b1);
    drop_pos = m_pos[0];
    n = 0;
    while (m_run[0] && n < 1000) begin
      apply_stimulus(1'b0, 1'b1, 24'($urandom), 1'b0);
      n++;
    end
    chk("drain_cycles", 0, n, 28 * 13 - drop_pos);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 24'($urandom), 1'b0);
    chk("idle_de", 0, de_o[0], 1'b0);
    chk("idle_ctrl0", 0, c0_o[0], 2'b11);
    chk("idle_ctrl0", 1, c0_o[1], 2'b00);
    apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
    apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
    chk("restart_frame_start", 0, fs_o[0], 1'b1);

    // Fully random traffic, including occasional enable drops and clears.
    for (int i = 0; i < 900; i++)
      apply_stimulus(rnd_pct(92), rnd_pct(85), 24'($urandom), rnd_pct(8));

    // Asynchronous reset between clock edges while both rasters are running.
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, rnd_pct(50), 24'($urandom), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check_output(k);
      chk("async_pix_ready", k, rdy_o[k], 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_output(k);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 24'($urandom), 1'b0);
    chk("stay_idle_de", 0, de_o[0], 1'b0);
    for (int i = 0; i < 300; i++)
      apply_stimulus(rnd_pct(95), rnd_pct(80), 24'($urandom), rnd_pct(10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
